// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
//
// A bank of independent programmable clock dividers. Each channel counts
// system-clock edges up to its active divisor D. It emits a one-cycle tick
// at every terminal count and toggles a 50%-duty divided clock level, so the
// divided clock has a period of 2*D cycles.
//
// A new divisor is accepted through a valid/ready handshake into a
// per-channel shadow register. It becomes active only at the channel's next
// terminal count, or on the next edge if the channel is disabled or sync is
// asserted, so the divided clock never glitches. A global sync restarts all
// channels in phase.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   en         per-channel run enable
//   sync       one-cycle restart of every channel
//   cfg_valid  divisor update request
//   cfg_ready  update can be accepted this cycle (combinational)
//   cfg_chan   target channel of the update
//   cfg_div    new divisor D (1 .. 2^CNT_W-1)
//   cfg_err    one-cycle pulse after a rejected request (D==0 or bad channel)
//   tick       per-channel one-cycle strobe at terminal count
//   clkout     per-channel divided clock level
// -----------------------------------------------------------------------------
module clk_div_bank #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 50000,
    localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHW-1:0]      cfg_chan,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clkout
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    // One extra bit so the channel count itself is representable (e.g. 16).
    localparam logic [CHW:0]     CHAN_LIM = (CHW + 1)'(CHANNELS);

    logic [CHANNELS-1:0] sel_vec;
    logic [CHANNELS-1:0] pend_vec;
    logic                chan_ok;
    logic                div_ok;
    logic                xfer;
    logic                cfg_err_reg;

    assign chan_ok = {1'b0, cfg_chan} < CHAN_LIM;
    assign div_ok  = (cfg_div != '0);

    // An out-of-range channel is always "ready" so that the request is
    // consumed and reported through cfg_err rather than stalling forever.
    assign cfg_ready = chan_ok ? ~|(pend_vec & sel_vec) : 1'b1;
    assign xfer      = cfg_valid && cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= xfer && !(chan_ok && div_ok);
        end
    end

    assign cfg_err = cfg_err_reg;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] div_reg;
        logic [CNT_W-1:0] nxt_reg;
        logic             pend_reg;
        logic             tick_reg;
        logic             clkout_reg;
        logic             at_term;
        logic             apply_now;
        logic             load_now;

        assign sel_vec[gi] = (cfg_chan == CHW'(gi));
        assign at_term     = (cnt_reg == (div_reg - ONE));

        // A pending divisor is swapped in whenever the counter restarts from
        // zero: terminal count, disable, or sync.
        assign apply_now = pend_reg && (sync || !en[gi] || at_term);
        assign load_now  = xfer && sel_vec[gi] && div_ok;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg    <= '0;
                div_reg    <= DIV_RST;
                nxt_reg    <= DIV_RST;
                pend_reg   <= 1'b0;
                tick_reg   <= 1'b0;
                clkout_reg <= 1'b0;
            end else begin
                // Sync wins over a coincident terminal count: no tick, no toggle.
                if (sync || !en[gi]) begin
                    cnt_reg    <= '0;
                    tick_reg   <= 1'b0;
                    clkout_reg <= 1'b0;
                end else if (at_term) begin
                    cnt_reg    <= '0;
                    tick_reg   <= 1'b1;
                    clkout_reg <= ~clkout_reg;
                end else begin
                    cnt_reg    <= cnt_reg + ONE;
                    tick_reg   <= 1'b0;
                end

                if (apply_now) begin
                    div_reg  <= nxt_reg;
                    pend_reg <= 1'b0;
                end

                // Placed after the apply so that a same-edge load leaves the
                // new value pending while the old shadow value goes active.
                if (load_now) begin
                    nxt_reg  <= cfg_div;
                    pend_reg <= 1'b1;
                end
            end
        end

        assign pend_vec[gi] = pend_reg;
        assign tick[gi]     = tick_reg;
        assign clkout[gi]   = clkout_reg;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
//
// Directed bench for clk_div_bank with 5 channels, 8-bit counters and a
// default divisor of 5. The stimulus issues one input vector per clock edge
// and pushes the hand-derived post-edge outputs into a scoreboard queue.
// A monitor pops one entry after every rising edge and compares the entry
// against tick, clkout, cfg_err and cfg_ready.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

    localparam int CH  = 5;
    localparam int CW  = 8;
    localparam int CHW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   en;
    logic            sync;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_chan;
    logic [CW-1:0]   cfg_div;
    logic            cfg_err;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   clkout;

    clk_div_bank #(
        .CHANNELS    (CH),
        .CNT_W       (CW),
        .DEFAULT_DIV (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .clkout    (clkout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        int            idx;
        logic [CH-1:0] tick;
        logic [CH-1:0] clkout;
        logic          err;
        logic          rdy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, expv);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled 1 time unit later.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.name, ".tick"},   e.idx, 32'(tick),      32'(e.tick));
                chk({e.name, ".clkout"}, e.idx, 32'(clkout),    32'(e.clkout));
                chk({e.name, ".err"},    e.idx, 32'(cfg_err),   32'(e.err));
                chk({e.name, ".rdy"},    e.idx, 32'(cfg_ready), 32'(e.rdy));
                $display("%0t %s[%0d] tick=%b clkout=%b err=%b rdy=%b", $time,
                         e.name, e.idx, tick, clkout, cfg_err, cfg_ready);
            end
        end
    end

    // Issue the current inputs for one edge and record the expected outputs.
    task automatic step(input string nm, input int k, input logic [CH-1:0] t,
                        input logic [CH-1:0] c, input logic e, input logic r);
        exp_t x;
        x.name = nm; x.idx = k; x.tick = t; x.clkout = c; x.err = e; x.rdy = r;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:15] a_tick;
        logic [1:15] a_clk;
        logic [1:10] c_tick;
        logic [1:10] c_clk;
        logic [1:10] c_rdy;
        logic [1:4]  d_tick;
        logic [1:4]  d_clk;
        logic [1:4]  d_err;
        logic [1:11] e_t0;
        logic [1:11] e_c0;
        logic [1:11] e_t2;
        logic [1:11] e_c2;
        logic [1:10] f_tick;
        logic [1:10] f_clk;

        a_tick = 15'b000010000100001;
        a_clk  = 15'b000011111000001;
        c_tick = 10'b0001010101;
        c_clk  = 10'b0001100110;
        c_rdy  = 10'b1001111111;
        d_tick = 4'b0101;
        d_clk  = 4'b0110;
        d_err  = 4'b1010;
        e_t0   = 11'b00000000010;
        e_c0   = 11'b00000000011;
        e_t2   = 11'b01010010101;
        e_c2   = 11'b01100011001;
        f_tick = 10'b0000100001;
        f_clk  = 10'b0000111110;

        rst_n = 1'b0; en = '0; sync = 1'b0;
        cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0;
        repeat (3) @(negedge clk);
        chk("rst.tick",   0, 32'(tick),      32'(0));
        chk("rst.clkout", 0, 32'(clkout),    32'(0));
        chk("rst.err",    0, 32'(cfg_err),   32'(0));
        chk("rst.rdy",    0, 32'(cfg_ready), 32'(1));

        // A: default divisor 5 on channel 0.
        en = 5'b00001; rst_n = 1'b1;
        for (int k = 1; k <= 15; k++)
            step("A", k, {4'b0, a_tick[k]}, {4'b0, a_clk[k]}, 1'b0, 1'b1);

        // B: load D=1 into disabled channel 1, then run it.
        en = '0; cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_div = 8'd1;
        step("B_cfg", 0, 5'b0, 5'b0, 1'b0, 1'b0);
        cfg_valid = 1'b0;
        step("B_apply", 0, 5'b0, 5'b0, 1'b0, 1'b1);
        en = 5'b00010;
        for (int k = 1; k <= 6; k++)
            step("B", k, 5'b00010, (k % 2 == 1) ? 5'b00010 : 5'b0, 1'b0, 1'b1);

        // C: channel 2 at D=4, reprogrammed to 2 while cnt==1.
        en = '0; cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_div = 8'd4;
        step("C_cfg", 0, 5'b0, 5'b0, 1'b0, 1'b0);
        cfg_valid = 1'b0;
        step("C_apply", 0, 5'b0, 5'b0, 1'b0, 1'b1);
        en = 5'b00100;
        for (int k = 1; k <= 10; k++) begin
            cfg_valid = (k == 2);
            cfg_div   = 8'd2;
            step("C", k, {2'b0, c_tick[k], 2'b0}, {2'b0, c_clk[k], 2'b0},
                 1'b0, c_rdy[k]);
        end

        // D: rejected requests (D==0, channel out of range) while ch2 runs.
        for (int k = 1; k <= 4; k++) begin
            cfg_valid = (k == 1) || (k == 3);
            cfg_chan  = (k <= 2) ? 3'd2 : 3'd5;
            cfg_div   = (k <= 2) ? 8'd0 : 8'd3;
            step("D", k, {2'b0, d_tick[k], 2'b0}, {2'b0, d_clk[k], 2'b0},
                 d_err[k], 1'b1);
        end

        // E: sync on channel 0's terminal count (edge 5).
        cfg_valid = 1'b0; cfg_chan = 3'd0; en = 5'b00101;
        for (int k = 1; k <= 11; k++) begin
            sync = (k == 5);
            step("E", k, {2'b0, e_t2[k], 1'b0, e_t0[k]},
                 {2'b0, e_c2[k], 1'b0, e_c0[k]}, 1'b0, 1'b1);
        end
        sync = 1'b0;

        // F: pending update on ch0, then reset mid-count discards it.
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 8'd3;
        step("F_cfg", 0, 5'b0, 5'b00101, 1'b0, 1'b0);
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("F_rst.tick",   0, 32'(tick),      32'(0));
        chk("F_rst.clkout", 0, 32'(clkout),    32'(0));
        chk("F_rst.rdy",    0, 32'(cfg_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++)
            step("F", k, f_tick[k] ? 5'b00101 : 5'b0,
                 f_clk[k] ? 5'b00101 : 5'b0, 1'b0, 1'b1);

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain got %0d entries left expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of independent programmable clock dividers for the mining datapath's slow-rate logic (display scan, UART baud, LED blink, status polling). Each channel divides the system clock by a runtime-programmable divisor and produces a 50%-duty divided clock level and a one-cycle tick strobe. Divisor updates use a valid/ready handshake and are applied glitch-free at the channel's next terminal count. A global sync input phase-aligns all channels.

## Interface
- CHANNELS, 4: number of divider channels (1..16).
- CNT_W, 16: divisor/counter width in bits.
- DEFAULT_DIV, 50000: divisor loaded into every channel at reset; must fit in CNT_W bits and be >= 1.
- CHW, $clog2(CHANNELS) (min 1): channel-select width, derived; not overridden.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  CHANNELS  per-channel run enable.
- sync  in  1  one-cycle restart of all channels.
- cfg_valid  in  1  divisor-update request.
- cfg_ready  out  1  update can be accepted this cycle.
- cfg_chan  in  CHW  target channel.
- cfg_div  in  CNT_W  new divisor D.
- cfg_err  out  1  one-cycle pulse: request rejected.
- tick  out  CHANNELS  one-cycle strobe per terminal count.
- clkout  out  CHANNELS  divided clock level, period 2*D cycles.

## Operation
- Per channel: active divisor div[c], shadow nxt[c], pending flag pend[c], counter cnt[c] (CNT_W bits).
- Reset values: cnt=0, div=DEFAULT_DIV, nxt=DEFAULT_DIV, pend=0, tick=0, clkout=0, cfg_err=0.
- Enabled channel, no sync: if cnt==div-1 then cnt<=0, tick<=1, clkout<=~clkout, and if pend then div<=nxt, pend<=0; else cnt<=cnt+1, tick<=0.
- Disabled channel (en[c]=0): cnt<=0, clkout<=0, tick<=0; if pend, div<=nxt and pend<=0 on that edge.
- sync=1: every channel cnt<=0, clkout<=0, tick<=0; pending divisors applied. Sync overrides a coincident terminal count (no tick, no toggle).
- Config handshake: cfg_ready = ~pend[cfg_chan] when cfg_chan < CHANNELS, else 1 (combinational). Transfer when cfg_valid && cfg_ready.
- On transfer: if cfg_div==0 or cfg_chan >= CHANNELS, request dropped and cfg_err<=1 next cycle; otherwise nxt[cfg_chan]<=cfg_div, pend[cfg_chan]<=1.
- Transfer and application on the same edge for the same channel: application uses the old nxt; new value becomes pending (pend stays 1). Cannot occur via handshake since cfg_ready=0 while pending; stated for completeness.
- Counter never exceeds div-1; no wrap beyond 2^CNT_W-1 because D <= 2^CNT_W-1.
- D=1: tick held high every cycle, clkout toggles every cycle.

## Timing
- tick and clkout are registered; both change on the edge at which cnt==div-1 is sampled.
- After rst_n release with en high: first tick at edge D (edges counted from 1), then every D edges; clkout rises at edge D, falls at edge 2D.
- Enable rising: first tick D edges after the first edge with en=1.
- cfg latency: update takes effect at the channel's next terminal count, i.e. at most old D edges after transfer; immediate (next edge) if channel disabled or sync asserted.
- cfg_err: registered, asserted exactly one cycle, edge after the rejected transfer.
- rst_n assertion mid-count: all outputs to reset values immediately (asynchronous), pending updates discarded.

## Test plan
- Reset, en=4'b0001, DEFAULT_DIV=5 -> tick[0] pulses at edges 5,10,15; clkout[0] high edges 5-9, low 10-14; other channels stay 0.
- D=1 on channel 1 -> tick[1] constant 1, clkout[1] toggles every cycle.
- Running with D=4, load cfg_div=2 at cnt=1 -> cfg_ready low until next terminal count, period 4 completes once, then ticks every 2 edges; cfg_ready returns high.
- cfg_div=0 or cfg_chan=5 with CHANNELS=4 -> no state change, cfg_err one-cycle pulse next cycle.
- sync asserted on a channel's terminal-count edge -> no tick, cnt and clkout 0, all channels' next ticks aligned D edges later.
- rst_n low mid-count with pending update -> all outputs 0 immediately; after release div=DEFAULT_DIV, pend=0.
